// File: rtl/regfile_pkg.sv
// Shared CPU constants and the read-port source selection used by the register file.
// The branch comparator, ALU and decoder import the same widths from here.
package regfile_pkg;

  localparam int CPU_XLEN = 32;
  localparam int CPU_NREG = 32;
  localparam int REG_AW   = 5;

  typedef enum logic [1:0] {
    SEL_STORED = 2'd0,
    SEL_RD     = 2'd1,
    SEL_ZERO   = 2'd2
  } byp_sel_e;

  // x0 and unimplemented registers read zero; a matching in-flight write is forwarded
  // only while out of reset, so reset reads always show the stored contents.
  function automatic byp_sel_e pick_sel(
    input logic              rst_n,
    input logic              wren,
    input logic [REG_AW-1:0] wr_addr,
    input logic [REG_AW-1:0] rd_addr,
    input logic              in_range
  );
    if (rd_addr == '0 || !in_range)
      return SEL_ZERO;
    else if (rst_n && wren && wr_addr == rd_addr)
      return SEL_RD;
    else
      return SEL_STORED;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port output mux: stored register value, write-through data, or zero.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
) (
  input  byp_sel_e          sel,
  input  logic [XLEN-1:0]   stored_data,
  input  logic [XLEN-1:0]   rd_data,
  output logic [XLEN-1:0]   rs_data
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves rs_data unassigned (no latch).
    rs_data = '0;
    case (sel)
      SEL_STORED: rs_data = stored_data;
      SEL_RD:     rs_data = rd_data;
      default:    rs_data = '0;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// Two-read, one-write integer register file with x0 hardwired to zero and a
// same-cycle write-through path so a reader sees the value being written this cycle.
module regfile
  import regfile_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int NREG = CPU_NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_wren,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data
);

  localparam logic [REG_AW:0] NREG_LIM = (REG_AW + 1)'(NREG);

  logic [XLEN-1:0] regs [NREG];

  logic     wr_in_range, rs1_in_range, rs2_in_range;
  byp_sel_e rs1_sel, rs2_sel;

  assign wr_in_range  = {1'b0, rd_addr}  < NREG_LIM;
  assign rs1_in_range = {1'b0, rs1_addr} < NREG_LIM;
  assign rs2_in_range = {1'b0, rs2_addr} < NREG_LIM;

  // NOTE: the storage array is cleared on reset because architectural state must read 0
  // afterwards; sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rd_wren && rd_addr != '0 && wr_in_range) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_sel = pick_sel(rst_n, rd_wren, rd_addr, rs1_addr, rs1_in_range);
  assign rs2_sel = pick_sel(rst_n, rd_wren, rd_addr, rs2_addr, rs2_in_range);

  regfile_bypass #(.XLEN(XLEN)) u_rs1_bypass (
    .sel         (rs1_sel),
    .stored_data (regs[rs1_addr]),
    .rd_data     (rd_data),
    .rs_data     (rs1_data)
  );

  regfile_bypass #(.XLEN(XLEN)) u_rs2_bypass (
    .sel         (rs2_sel),
    .stored_data (regs[rs2_addr]),
    .rd_data     (rd_data),
    .rs_data     (rs2_data)
  );

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 Parameter NREG, default 32, number of architectural registers; address width is log2(NREG) = 5.
REQ-003 The ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- rd_wren  in  1  write enable
- rd_addr  in  5  write address
- rd_data  in  XLEN  write data
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  XLEN  read port 1 data, feeds the branch comparator A input and the ALU
- rs2_data  out  XLEN  read port 2 data, feeds the branch comparator B input, ALU and store path
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-low, sampled on the rising edge of clk.

Function
REQ-005 Storage SHALL be NREG registers of XLEN bits each, written only on the rising edge of clk.
REQ-006 On a clk edge with rst_n=1, rd_wren=1 and rd_addr!=0, register[rd_addr] SHALL take rd_data.
REQ-007 A write to rd_addr=0 SHALL be discarded, and register x0 SHALL read 0 at all times.
REQ-008 A clk edge with rd_wren=0 SHALL leave every register unchanged.
REQ-009 Read ports SHALL be combinational with zero-cycle latency: rsN_data = register[rsN_addr].
REQ-010 Write-through bypass: when rd_wren=1, rd_addr!=0 and rd_addr==rsN_addr, rsN_data SHALL equal rd_data in the same cycle, before the clock edge.
REQ-011 When rsN_addr=0, rsN_data SHALL be 0 regardless of rd_wren, rd_addr and rd_data.
REQ-012 Both read ports SHALL be independent; rs1_addr==rs2_addr SHALL return identical data on both ports, including the bypass case.
REQ-013 Reads SHALL have no side effects, and the block SHALL have no stall, busy or handshake signals; a write is accepted every cycle it is enabled.
REQ-014 Out-of-range addresses cannot occur for NREG=32; for NREG<32, writes to an address >=NREG SHALL be ignored and reads from one SHALL return 0.

Reset
REQ-015 On a clk edge with rst_n=0, all NREG registers SHALL clear to 0, overriding any write in the same cycle.
REQ-016 While rst_n=0, rs1_data and rs2_data SHALL reflect the stored value, which is 0 after the first reset edge; the bypass SHALL be disabled while rst_n=0.
REQ-017 Reset asserted mid-program SHALL discard all register contents; the first write after rst_n rises SHALL take effect on the next clk edge.

Structure
REQ-018 XLEN, NREG and the register-address width constant SHALL live in the shared CPU package, which is also used by the branch comparator, ALU and decoder.
REQ-019 The block SHALL contain one sub-module, regfile_bypass: a combinational per-port mux that selects between stored data, rd_data and zero. It SHALL be instantiated twice.
REQ-020 Storage SHALL be an array of flops with no inferred latches.

Verification
REQ-021 Reset clears: write 0xFFFF_FFFF to x1..x31, assert rst_n=0 for 1 cycle, then read every register -> all 0.
REQ-022 x0 immutable: write 0xDEAD_BEEF to x0 with rd_wren=1 -> rs1_data=rs2_data=0 in the write cycle and every later cycle.
REQ-023 Bypass: write 0x8000_0000 to x5 with rs1_addr=rs2_addr=5 in the same cycle -> both ports show 0x8000_0000 before the edge; after the edge the stored value is 0x8000_0000.
REQ-024 Write disabled: x7=0x1234, then rd_wren=0, rd_addr=7, rd_data=0x5678 -> x7 still reads 0x1234 and no bypass occurs.
REQ-025 Comparator feed: x3=0xFFFF_FFFF, x4=0x0000_0001, rs1_addr=3, rs2_addr=4 -> rs1_data=0xFFFF_FFFF, rs2_data=0x1; a connected comparator gives br_less=1 for signed and 0 for unsigned.
REQ-026 Reset priority: rst_n=0 and rd_wren=1 to x9 with 0xAAAA in the same edge -> x9 reads 0 after the edge.
